// File: rtl/mips_mc_pkg.sv
// Shared types and ISA constants for the multi-cycle MIPS control unit.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       iord;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       pc_write;
      logic       branch;
      aluop_e     aluop;
   } ctrl_t;

   // Control word for a step that touches nothing: no writes, all selects 0, ALU adds.
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c       = '0;
      c.aluop = ALUOP_ADD;
      return c;
   endfunction

endpackage

// File: rtl/mips_mc_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop and the R-type funct field to alu_control.
module alu_decoder
   import mips_mc_pkg::*;
(
   input  aluop_e     aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      // NOTE: assigning a default first means every path drives the output, so no latch is inferred.
      alu_control_o = ALU_ADD;
      case (aluop_i)
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FN_ADD:  alu_control_o = ALU_ADD;
               FN_SUB:  alu_control_o = ALU_SUB;
               FN_AND:  alu_control_o = ALU_AND;
               FN_OR:   alu_control_o = ALU_OR;
               FN_SLT:  alu_control_o = ALU_SLT;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing the shared datapath, one step per clock.
module mips_mc_control
   import mips_mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       pc_en,
   output logic [2:0] alu_control,
   output logic [3:0] state
);

   state_e state_q, state_d, state_view;
   ctrl_t  ctrl;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = S_MEMWB;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values, matching the hardware.
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // During reset the outputs look like FETCH so an aborted step cannot leave a stray select or write.
   assign state_view = rst ? S_FETCH : state_q;

   always_comb begin
      ctrl = ctrl_idle();
      case (state_view)
         S_FETCH: begin
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
         end
         S_DECODE: ctrl.alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.aluop     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.aluop     = ALUOP_SUB;
            ctrl.pc_src    = 2'b01;
            ctrl.branch    = 1'b1;
         end
         S_ADDIWB: ctrl.reg_write = 1'b1;
         S_JUMP: begin
            ctrl.pc_src   = 2'b10;
            ctrl.pc_write = 1'b1;
         end
         default: ctrl = ctrl_idle();
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop_i       (ctrl.aluop),
      .funct_i       (funct),
      .alu_control_o (alu_control)
   );

   assign iord       = ctrl.iord;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign pc_src     = ctrl.pc_src;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign ir_write   = ctrl.ir_write  & ~rst;
   assign mem_write  = ctrl.mem_write & ~rst;
   assign reg_write  = ctrl.reg_write & ~rst;
   assign pc_en      = (ctrl.pc_write | (ctrl.branch & zero)) & ~rst;
   assign state      = state_view;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: instruction-level model of expected per-cycle control words.
module tb_mips_mc_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       zero;
   logic       iord, alu_src_a, reg_dst, mem_to_reg;
   logic       ir_write, mem_write, reg_write, pc_en;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state;
   logic [18:0] got;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mips_mc_control dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .iord        (iord),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .ir_write    (ir_write),
      .mem_write   (mem_write),
      .reg_write   (reg_write),
      .pc_en       (pc_en),
      .alu_control (alu_control),
      .state       (state)
   );

   assign got = {state, iord, alu_src_a, alu_src_b, pc_src, reg_dst, mem_to_reg,
                 ir_write, mem_write, reg_write, pc_en, alu_control};

   function automatic logic [18:0] pack(input logic [3:0] st, input logic io, input logic sa,
                                        input logic [1:0] sb, input logic [1:0] ps, input logic rd,
                                        input logic m2r, input logic irw, input logic mw,
                                        input logic rw, input logic pce, input logic [2:0] alu);
      return {st, io, sa, sb, ps, rd, m2r, irw, mw, rw, pce, alu};
   endfunction

   function automatic int cpi_of(input logic [5:0] op);
      case (op)
         6'b100011: return 5;
         6'b101011: return 4;
         6'b000000: return 4;
         6'b001000: return 4;
         6'b000100: return 3;
         6'b000010: return 3;
         default:   return 2;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected control word for the given step (0 = fetch) of one instruction.
   function automatic logic [18:0] model(input logic [5:0] op, input logic [5:0] fn,
                                         input logic z, input int step);
      logic [18:0] r;
      r = pack(4'd0, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 1, 3'b010);
      if (step == 1) r = pack(4'd1, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010);
      if (step >= 2) begin
         case (op)
            6'b100011: begin
               if (step == 2) r = pack(4'd2, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010);
               if (step == 3) r = pack(4'd3, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010);
               if (step == 4) r = pack(4'd4, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0, 3'b010);
            end
            6'b101011: begin
               if (step == 2) r = pack(4'd2, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010);
               if (step == 3) r = pack(4'd5, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 3'b010);
            end
            6'b000000: begin
               if (step == 2) r = pack(4'd6, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, funct_alu(fn));
               if (step == 3) r = pack(4'd7, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 3'b010);
            end
            6'b000100: r = pack(4'd8, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, z, 3'b110);
            6'b001000: begin
               if (step == 2) r = pack(4'd9, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010);
               if (step == 3) r = pack(4'd10, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 3'b010);
            end
            6'b000010: r = pack(4'd11, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 1, 3'b010);
            default: ;
         endcase
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got_v, exp_v);
   endtask

   // Called 1 time unit after a rising edge with the FSM in FETCH.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input bit rand_z, input int exp_cpi);
      int  steps = 0;
      bit  done  = 0;
      opcode = op;
      funct  = fn;
      zero   = z;
      while (!done && steps < 12) begin
         if (rand_z) zero = 1'($urandom_range(0, 1));
         @(negedge clk);
         check($sformatf("%s step%0d", name, steps), 32'(got), 32'(model(op, fn, zero, steps)));
         steps++;
         @(posedge clk);
         #1;
         if (state == 4'd0) done = 1;
      end
      check($sformatf("%s cpi", name), 32'(steps), 32'(exp_cpi));
   endtask

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         cpi;
   } vec_t;

   vec_t tbl[$];
   localparam logic [18:0] RESET_WORD = 19'({4'd0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0,
                                              1'b0, 1'b0, 1'b0, 1'b0, 3'b010});

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      opcode = 6'b100011;
      funct  = 6'b000000;
      zero   = 1'b0;

      repeat (3) begin
         @(negedge clk);
         check("reset hold", 32'(got), 32'(RESET_WORD));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      tbl.push_back('{"lw",       6'b100011, 6'b000000, 1'b0, 5});
      tbl.push_back('{"sw",       6'b101011, 6'b000000, 1'b0, 4});
      tbl.push_back('{"r_add",    6'b000000, 6'b100000, 1'b0, 4});
      tbl.push_back('{"r_sub",    6'b000000, 6'b100010, 1'b1, 4});
      tbl.push_back('{"r_and",    6'b000000, 6'b100100, 1'b0, 4});
      tbl.push_back('{"r_or",     6'b000000, 6'b100101, 1'b0, 4});
      tbl.push_back('{"r_slt",    6'b000000, 6'b101010, 1'b0, 4});
      tbl.push_back('{"r_badfn",  6'b000000, 6'b111111, 1'b0, 4});
      tbl.push_back('{"beq_z1",   6'b000100, 6'b000000, 1'b1, 3});
      tbl.push_back('{"beq_z0",   6'b000100, 6'b000000, 1'b0, 3});
      tbl.push_back('{"addi",     6'b001000, 6'b000000, 1'b0, 4});
      tbl.push_back('{"j",        6'b000010, 6'b000000, 1'b0, 3});
      tbl.push_back('{"illegal3f", 6'b111111, 6'b000000, 1'b0, 2});
      tbl.push_back('{"illegal01", 6'b000001, 6'b101010, 1'b1, 2});

      foreach (tbl[i]) run_instr(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].z, 1'b0, tbl[i].cpi);

      // sw aborted by reset while in MEMWR: no memory write that cycle, restart at FETCH.
      opcode = 6'b101011;
      funct  = 6'b000000;
      zero   = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check($sformatf("sw_abort step%0d", s), 32'(got), 32'(model(6'b101011, 6'b000000, 1'b0, s)));
         @(posedge clk);
         #1;
      end
      check("sw_abort in MEMWR", 32'(state), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      check("sw_abort mem_write", 32'(mem_write), 32'd0);
      check("sw_abort word", 32'(got), 32'(RESET_WORD));
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_instr("post_abort_lw", 6'b100011, 6'b000000, 1'b0, 1'b0, 5);

      for (int k = 0; k < 150; k++) begin
         logic [5:0] op, fn;
         case ($urandom_range(0, 7))
            0:       op = 6'b100011;
            1:       op = 6'b101011;
            2:       op = 6'b000000;
            3:       op = 6'b000100;
            4:       op = 6'b001000;
            5:       op = 6'b000010;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       fn = 6'b100000;
            1:       fn = 6'b100010;
            2:       fn = 6'b100100;
            3:       fn = 6'b100101;
            4:       fn = 6'b101010;
            default: fn = 6'($urandom);
         endcase
         run_instr($sformatf("rnd%0d_op%02h_fn%02h", k, op, fn), op, fn, 1'b0, 1'b1, cpi_of(op));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
